// File: rtl/set_assoc_cache_if.sv
// rtl/set_assoc_cache_if.sv - request, response, memory-port and statistics bundle for set_assoc_cache
interface set_assoc_cache_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_hit;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [31:0]           hit_counter;
    logic [31:0]           miss_counter;
    logic [31:0]           total_requests;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_hit,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output hit_counter, miss_counter, total_requests
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_hit,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  hit_counter, miss_counter, total_requests
    );
endinterface

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - N-way set-associative write-back/write-allocate cache with true LRU
// Optional hit/miss/total statistics counters built when CACHE_STATS_EN is defined.
module set_assoc_cache #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int SETS       = 8,
    parameter int WAYS       = 2
) (
    input logic              clk,
    input logic              reset,
    set_assoc_cache_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, REFILL} state_e;

    state_e state_q, state_d;

    logic                  valid_q [SETS][WAYS];
    logic                  dirty_q [SETS][WAYS];
    logic [WAY_W-1:0]      age_q   [SETS][WAYS];
    logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];

    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [WAY_W-1:0]      victim_q, victim_d;

    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_hit_q, resp_hit_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [IDX_W-1:0]      set_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim;
    logic                  free_found;
    logic                  hit_wr, install, wb_done, lru_en;
    logic [WAY_W-1:0]      lru_way;
    logic [DATA_WIDTH-1:0] fill_data;

    assign set_idx   = addr_q[IDX_W-1:0];
    assign req_tag   = addr_q[ADDR_WIDTH-1:IDX_W];
    assign fill_data = wr_q ? wdata_q : bus.mem_rdata;

    // Victim: lowest-index invalid way, else the oldest (age WAYS-1).
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim     = '0;
        free_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[set_idx][w]) begin
                free_found = 1'b1;
                victim     = WAY_W'(w);
            end
        end
        if (!free_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[set_idx][w] == WAY_W'(WAYS - 1)) begin
                    victim = WAY_W'(w);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        victim_d     = victim_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_hit_d   = resp_hit_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hit_wr       = 1'b0;
        install      = 1'b0;
        wb_done      = 1'b0;
        lru_en       = 1'b0;
        lru_way      = hit_way;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    resp_valid_d = 1'b1;
                    resp_hit_d   = 1'b1;
                    lru_en       = 1'b1;
                    hit_wr       = wr_q;
                    resp_rdata_d = wr_q ? wdata_q : data_q[set_idx][hit_way];
                    state_d      = IDLE;
                end else begin
                    victim_d  = victim;
                    mem_req_d = 1'b1;
                    if (valid_q[set_idx][victim] && dirty_q[set_idx][victim]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[set_idx][victim], set_idx};
                        mem_wdata_d = data_q[set_idx][victim];
                        state_d     = WRITEBACK;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = addr_q;
                        state_d    = REFILL;
                    end
                end
            end
            WRITEBACK: begin
                if (bus.mem_ack) begin
                    wb_done   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = REFILL;
                end
            end
            REFILL: begin
                // mem_req low here means we arrived from WRITEBACK and still owe the one-cycle gap.
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_q;
                end else if (bus.mem_ack) begin
                    install      = 1'b1;
                    lru_en       = 1'b1;
                    lru_way      = victim_q;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_hit_d   = 1'b0;
                    resp_rdata_d = fill_data;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            victim_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_hit_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            victim_q     <= victim_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_hit_q   <= resp_hit_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if (install) begin
                valid_q[set_idx][victim_q] <= 1'b1;
                dirty_q[set_idx][victim_q] <= wr_q;
            end
            if (hit_wr) begin
                dirty_q[set_idx][hit_way] <= 1'b1;
            end
            if (wb_done) begin
                dirty_q[set_idx][victim_q] <= 1'b0;
            end
            if (lru_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == lru_way) begin
                        age_q[set_idx][w] <= '0;
                    end else if (age_q[set_idx][w] < age_q[set_idx][lru_way]) begin
                        age_q[set_idx][w] <= age_q[set_idx][w] + WAY_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (hit_wr) begin
                data_q[set_idx][hit_way] <= wdata_q;
            end
            if (install) begin
                data_q[set_idx][victim_q] <= fill_data;
                tag_q[set_idx][victim_q]  <= req_tag;
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_hit   = resp_hit_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, total_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            total_cnt_q <= '0;
        end else if (state_q == COMPARE) begin
            total_cnt_q <= total_cnt_q + 32'd1;
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign bus.hit_counter    = hit_cnt_q;
    assign bus.miss_counter   = miss_cnt_q;
    assign bus.total_requests = total_cnt_q;
`else
    assign bus.hit_counter    = '0;
    assign bus.miss_counter   = '0;
    assign bus.total_requests = '0;
`endif
endmodule
